// File: rtl/alu_pipe.sv
// Handshaked ALU: one op per valid/ready transfer, registered result and flags held until consumed.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier; otherwise opcode 011 reports o_bi_err.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_ul_a,
  input  logic [WIDTH-1:0] i_ul_b,
  input  logic [2:0]       i_u3_sel,
  input  logic             i_bi_valid,
  output logic             o_bi_ready,
  output logic [WIDTH-1:0] o_ul_r,
  output logic             o_bi_valid,
  input  logic             i_bi_ready,
  output logic             o_bi_zflag,
  output logic             o_bi_cflag,
  output logic             o_bi_vflag,
  output logic             o_bi_err
);

  localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_PIPE_MUL_EN
  localparam int CNT_W = SH_W + 1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DONE = 1'b1} state_t;
`endif

  state_t state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

  logic             accept;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sub_w;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_err;

`ifdef ALU_PIPE_MUL_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
`endif

  assign o_bi_ready = !rst && (state_q == ST_IDLE || (state_q == ST_DONE && i_bi_ready));
  assign accept     = i_bi_valid && o_bi_ready;
  assign o_bi_valid = (state_q == ST_DONE);
  assign o_ul_r     = r_q;
  assign o_bi_zflag = z_q;
  assign o_bi_cflag = c_q;
  assign o_bi_vflag = v_q;
  assign o_bi_err   = err_q;

  always_comb begin
    add_w   = {1'b0, i_ul_a} + {1'b0, i_ul_b};
    sub_w   = i_ul_a - i_ul_b;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (i_u3_sel)
      3'b000: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (i_ul_a[WIDTH-1] == i_ul_b[WIDTH-1]) && (alu_r[WIDTH-1] != i_ul_a[WIDTH-1]);
      end
      3'b001: alu_r = i_ul_a & i_ul_b;
      3'b010: alu_r = i_ul_a | i_ul_b;
`ifdef ALU_PIPE_MUL_EN
      3'b011: alu_r = '0;
`else
      3'b011: alu_err = 1'b1;
`endif
      3'b100: begin
        alu_r = sub_w;
        alu_c = (i_ul_a < i_ul_b);
        alu_v = (i_ul_a[WIDTH-1] != i_ul_b[WIDTH-1]) && (alu_r[WIDTH-1] != i_ul_a[WIDTH-1]);
      end
      3'b101: alu_r = {{(WIDTH-1){1'b0}}, (i_ul_a < i_ul_b)};
      3'b110: alu_r = i_ul_a ^ i_ul_b;
      3'b111: alu_r = i_ul_a << i_ul_b[SH_W-1:0];
      default: alu_r = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  // Multiplier lives in the low half of acc; each step adds mcand into the high half and shifts right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
`ifdef ALU_PIPE_MUL_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (i_u3_sel == 3'b011) begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, i_ul_b};
            mcand_d = i_ul_a;
          end else
`endif
          begin
            state_d = ST_DONE;
            r_d     = alu_r;
            z_d     = (alu_r == '0);
            c_d     = alu_c;
            v_d     = alu_v;
            err_d   = alu_err;
          end
        end else if (state_q == ST_DONE && i_bi_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      ST_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          r_d     = acc_step[WIDTH-1:0];
          z_d     = (acc_step[WIDTH-1:0] == '0);
          c_d     = 1'b0;
          v_d     = |acc_step[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
`ifdef ALU_PIPE_MUL_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes hand-computed results on accept, monitor checks on consumption.
// Expectations follow ALU_PIPE_MUL_EN the same way the design does.
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_ul_a, i_ul_b;
  logic [2:0]   i_u3_sel;
  logic         i_bi_valid;
  logic         o_bi_ready;
  logic [W-1:0] o_ul_r;
  logic         o_bi_valid;
  logic         i_bi_ready;
  logic         o_bi_zflag, o_bi_cflag, o_bi_vflag, o_bi_err;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z, c, v, err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_ul_a(i_ul_a), .i_ul_b(i_ul_b), .i_u3_sel(i_u3_sel),
    .i_bi_valid(i_bi_valid), .o_bi_ready(o_bi_ready), .o_ul_r(o_ul_r),
    .o_bi_valid(o_bi_valid), .i_bi_ready(i_bi_ready), .o_bi_zflag(o_bi_zflag),
    .o_bi_cflag(o_bi_cflag), .o_bi_vflag(o_bi_vflag), .o_bi_err(o_bi_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, c, v, err);
    exp_t e;
    e.r = r; e.z = z; e.c = c; e.v = v; e.err = err;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, output int waited);
    i_u3_sel = op; i_ul_a = a; i_ul_b = b; i_bi_valid = 1'b1;
    waited = 0;
    #1;
    while (!o_bi_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: op %0d never accepted", op);
    end else begin
      sb.push_back(e);
    end
    @(negedge clk);
    i_bi_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && o_bi_valid && i_bi_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got r=0x%08h with nothing expected", o_ul_r);
        end else begin
          e = sb.pop_front();
          if (o_ul_r !== e.r || o_bi_zflag !== e.z || o_bi_cflag !== e.c ||
              o_bi_vflag !== e.v || o_bi_err !== e.err) begin
            errors++;
            $display("FAIL result: got r=0x%08h z%0b c%0b v%0b err%0b expected r=0x%08h z%0b c%0b v%0b err%0b",
                     o_ul_r, o_bi_zflag, o_bi_cflag, o_bi_vflag, o_bi_err,
                     e.r, e.z, e.c, e.v, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r"},     o_ul_r, '0);
    chk({tag, "_flags"}, {29'd0, o_bi_zflag, o_bi_cflag, o_bi_vflag}, '0);
    chk({tag, "_err"},   {31'd0, o_bi_err}, '0);
    chk({tag, "_valid"}, {31'd0, o_bi_valid}, '0);
    chk({tag, "_ready"}, {31'd0, o_bi_ready}, '0);
  endtask

  initial begin : driver
    int w;
    int k;
    rst = 1'b1; i_bi_valid = 1'b0; i_bi_ready = 1'b0;
    i_ul_a = '0; i_ul_b = '0; i_u3_sel = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    i_bi_ready = 1'b1;

    // Carry wrap, then signed-overflow subtract; both must show after one edge.
    send(3'b000, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 1, 0, 0), w);
    chk("add_latency_valid", {31'd0, o_bi_valid}, 32'd1);
    send(3'b100, 32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 0, 0, 1, 0), w);
    chk("sub_latency_valid", {31'd0, o_bi_valid}, 32'd1);
    send(3'b100, 32'd3, 32'd5, mk(32'hFFFF_FFFE, 0, 1, 0, 0), w);
    send(3'b000, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 0, 0, 1, 0), w);

    // Back-to-back stream: every op accepted immediately, valid never drops.
    send(3'b001, 32'hF0F0_1234, 32'h0FF0_FF00, mk(32'h00F0_1200, 0, 0, 0, 0), w);
    chk("stream_and_nowait", w, 0);
    send(3'b010, 32'hF000_0000, 32'h0000_000F, mk(32'hF000_000F, 0, 0, 0, 0), w);
    chk("stream_or_nowait", w, 0);
    chk("stream_or_valid", {31'd0, o_bi_valid}, 32'd1);
    send(3'b110, 32'hAAAA_AAAA, 32'hAAAA_AAAA, mk(32'h0, 1, 0, 0, 0), w);
    chk("stream_xor_nowait", w, 0);
    send(3'b101, 32'd3, 32'd5, mk(32'd1, 0, 0, 0, 0), w);
    chk("stream_slt_nowait", w, 0);
    send(3'b111, 32'd1, 32'h25, mk(32'h20, 0, 0, 0, 0), w);
    chk("stream_shl_nowait", w, 0);
    chk("stream_shl_valid", {31'd0, o_bi_valid}, 32'd1);
    send(3'b101, 32'd5, 32'd3, mk(32'd0, 1, 0, 0, 0), w);
    @(negedge clk);

`ifdef ALU_PIPE_MUL_EN
    // Each multiply: ready low and valid low until exactly W edges after accept.
    send(3'b011, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 1, 0, 1, 0), w);
    #1;
    k = 0;
    while (!o_bi_valid && k < W + 5) begin
      if (o_bi_ready) begin
        checks++; errors++;
        $display("FAIL mul_ready_low: ready high at cycle %0d", k);
      end
      @(negedge clk); #1;
      k++;
    end
    chk("mul_big_latency", k, W);
    @(negedge clk);
    send(3'b011, 32'd7, 32'd6, mk(32'd42, 0, 0, 0, 0), w);
    #1;
    k = 0;
    while (!o_bi_valid && k < W + 5) begin
      @(negedge clk); #1;
      k++;
    end
    chk("mul_small_latency", k, W);
    @(negedge clk);
    send(3'b011, 32'd0, 32'hFFFF_FFFF, mk(32'd0, 1, 0, 0, 0), w);
    #1;
    k = 0;
    while (!o_bi_valid && k < W + 5) begin
      @(negedge clk); #1;
      k++;
    end
    chk("mul_zero_latency", k, W);
    @(negedge clk);
`else
    send(3'b011, 32'd7, 32'd6, mk(32'd0, 1, 0, 0, 1), w);
    chk("mul_off_latency_valid", {31'd0, o_bi_valid}, 32'd1);
    send(3'b000, 32'd0, 32'd0, mk(32'd0, 1, 0, 0, 0), w);
    chk("mul_off_add_valid", {31'd0, o_bi_valid}, 32'd1);
    @(negedge clk);
`endif

    // Backpressure: result held while operands churn, then consume and accept in one cycle.
    i_bi_ready = 1'b0;
    send(3'b010, 32'h0000_1234, 32'h0000_00FF, mk(32'h0000_12FF, 0, 0, 0, 0), w);
    for (int i = 0; i < 5; i++) begin
      i_bi_valid = 1'b1;
      i_u3_sel   = 3'($urandom_range(0, 7));
      i_ul_a     = $urandom;
      i_ul_b     = $urandom;
      #2;
      chk("stall_r", o_ul_r, 32'h0000_12FF);
      chk("stall_valid_ready", {30'd0, o_bi_valid, o_bi_ready}, 32'd2);
      @(negedge clk);
    end
    i_bi_ready = 1'b1;
    send(3'b000, 32'd2, 32'd3, mk(32'd5, 0, 0, 0, 0), w);
    chk("release_same_cycle_accept", w, 0);
    chk("release_new_valid", {31'd0, o_bi_valid}, 32'd1);
    @(negedge clk);

    // Reset in the middle of an operation discards it.
`ifdef ALU_PIPE_MUL_EN
    send(3'b011, 32'd9, 32'd9, mk(32'd81, 0, 0, 0, 0), w);
    repeat (3) @(negedge clk);
`else
    i_bi_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, mk(32'd2, 0, 0, 0, 0), w);
    @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    chk_reset_outputs("midop_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    i_bi_ready = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_ready", {31'd0, o_bi_ready}, 32'd1);
    chk("post_reset_valid", {31'd0, o_bi_valid}, 32'd0);
    @(negedge clk);
    send(3'b110, 32'h1234_5678, 32'hFFFF_0000, mk(32'hEDCB_5678, 0, 0, 0, 0), w);
    @(negedge clk);

    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results never arrived", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's single-cycle 32-bit ALU. Accepts one operation per valid/ready transfer, computes it in one cycle, or over WIDTH cycles for an iterative multiply, and holds a registered result with zero/carry/overflow flags until the consumer takes it. It sits between the operand-fetch stage and the writeback/flag register of the datapath and can stall in both directions.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥4
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- i_ul_a  input  WIDTH  operand A
- i_ul_b  input  WIDTH  operand B
- i_u3_sel  input  3  opcode
- i_bi_valid  input  1  operands/opcode valid
- o_bi_ready  output  1  block can accept this cycle
- o_ul_r  output  WIDTH  result (registered)
- o_bi_valid  output  1  result valid
- i_bi_ready  input  1  consumer takes result
- o_bi_zflag  output  1  result == 0
- o_bi_cflag  output  1  carry / borrow
- o_bi_vflag  output  1  signed overflow / multiply overflow
- o_bi_err  output  1  opcode unsupported in this build

## Operation
- Opcodes: 000 A+B; 001 A&B; 010 A|B; 011 A*B, low WIDTH bits; 100 A−B; 101 unsigned A<B → 1, else 0; 110 A^B; 111 A<<B[log2(WIDTH)−1:0].
- Flags are computed from the same result that is registered into o_ul_r, never from the previous result.
  - zflag = (result == 0).
  - ADD: cflag = carry out; vflag = signed overflow.
  - SUB: cflag = borrow (A<B unsigned); vflag = signed overflow.
  - MUL: cflag = 0; vflag = 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other ops: cflag = vflag = 0.
- State machine:
  - IDLE → DONE on accept of a non-MUL op.
  - IDLE → MUL on accept of MUL. MUL runs a shift-add over a 2·WIDTH accumulator with a down-counter loaded to WIDTH, then → DONE.
  - DONE → IDLE when i_bi_ready = 1 and no new accept.
  - DONE → DONE or MUL when i_bi_ready = 1 and a new op is accepted in the same cycle.
- o_bi_ready = !rst && (state == IDLE || (state == DONE && i_bi_ready)). It is 0 throughout MUL.
- Accept = i_bi_valid && o_bi_ready. Operands and opcode are captured only on accept. Changes to the inputs at any other time are ignored.
- o_bi_valid = 1 exactly in DONE. o_ul_r and the flags stay stable while o_bi_valid && !i_bi_ready.
- o_bi_err is registered with the result. It is 1 only for an unsupported opcode (see Configuration); in that case the result is 0, zflag = 1, cflag = vflag = 0.

## Timing
- Reset values: o_ul_r = 0, all flags = 0, o_bi_err = 0, o_bi_valid = 0, o_bi_ready = 0 while rst is high. State = IDLE, counter = 0.
- Reset asserted mid-MUL or mid-DONE aborts the operation at once; the pending result is discarded.
- Non-MUL ops: accept on edge n → o_bi_valid high and result visible after edge n.
- Back-to-back non-MUL ops with i_bi_ready held at 1 sustain one result per cycle.
- MUL: accept on edge n → o_bi_valid high after edge n+WIDTH. o_bi_ready is low from edge n until the result is consumed.
- Stall: o_bi_valid stays high and the result is held indefinitely while i_bi_ready = 0.
- Shift amount ≥ WIDTH cannot occur, because only log2(WIDTH) bits of B are used.
- MUL with an operand of 0 still takes the full WIDTH iterations. There is no early exit.

## Configuration
- ALU_PIPE_MUL_EN defined: the MUL state, counter and 2·WIDTH accumulator are built, and opcode 011 behaves as specified above.
- ALU_PIPE_MUL_EN undefined: no MUL state or multiplier hardware. Opcode 011 completes like a non-MUL op with 1-cycle latency: o_ul_r = 0, zflag = 1, o_bi_err = 1. All other opcodes are unchanged.

## Test plan
- Reset, WIDTH = 32: assert rst mid-MUL → all outputs 0 immediately. Deassert → o_bi_ready = 1 on the next cycle, o_bi_valid = 0.
- ADD 0xFFFFFFFF + 1, i_bi_ready = 1 → one cycle later r = 0, z = 1, c = 1, v = 0. Then SUB 0x80000000 − 1 → r = 0x7FFFFFFF, c = 0, v = 1.
- Back-to-back stream: AND, OR, XOR, SLT(3,5) = 1, SHL(1, B = 0x25) = 0x20, one accept per cycle → results in order, one per cycle, no bubbles.
- MUL 0x10000 × 0x10000 with ALU_PIPE_MUL_EN → o_bi_ready low for the operation; after 32 edges r = 0, z = 1, v = 1. MUL 7 × 6 → r = 42, v = 0.
- Backpressure: hold i_bi_ready = 0 for 5 cycles after a result appears, toggling operand inputs → r/flags unchanged, o_bi_ready = 0. Release → consumed, and a new accept occurs in the same cycle.
- Build without ALU_PIPE_MUL_EN: opcode 011 → 1-cycle latency, r = 0, z = 1, err = 1. Opcode 000 → err = 0.
